// File: rtl/bus_pkg.sv
// Shared types and constants for the two-core shared memory bus.
// Imported by the arbiter and the system_bus top level.
package bus_pkg;

  localparam int BUS_ADDR_W = 9;
  localparam int BUS_DATA_W = 8;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } bus_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin ownership FSM.
// Grants are decoded straight from the state register.
module rr_arbiter2
  import bus_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic grant0,
  output logic grant1
);

  bus_state_t state_q;
  bus_state_t state_d;
  logic       last_owner;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1)
          state_d = last_owner ? OWN0 : OWN1;
        else if (req0)
          state_d = OWN0;
        else if (req1)
          state_d = OWN1;
      end
      OWN0: if (!req0) state_d = req1 ? OWN1 : IDLE;
      OWN1: if (!req1) state_d = req0 ? OWN0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // last_owner resets to 1 so core0 wins the first contention
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_owner <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_d == OWN0)
        last_owner <= 1'b0;
      else if (state_d == OWN1)
        last_owner <= 1'b1;
    end
  end

  assign grant0 = (state_q == OWN0);
  assign grant1 = (state_q == OWN1);

endmodule

// File: rtl/system_bus.sv
// Shared bus between core0/core1 and gpiomem.
// Owner's signals are muxed to memory; read data returns to owner only.
module system_bus
  import bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core0_request,
  output logic              core0_grant,
  input  logic [DATA_W-1:0] core0_data_in,
  output logic [DATA_W-1:0] core0_data_out,
  input  logic [ADDR_W-1:0] core0_address,
  input  logic              core0_rw,
  input  logic              core1_request,
  output logic              core1_grant,
  input  logic [DATA_W-1:0] core1_data_in,
  output logic [DATA_W-1:0] core1_data_out,
  input  logic [ADDR_W-1:0] core1_address,
  input  logic              core1_rw,
  output logic [ADDR_W-1:0] RAM_address,
  output logic [DATA_W-1:0] RAM_data_in,
  input  logic [DATA_W-1:0] RAM_data_out,
  output logic              rw
);

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req0   (core0_request),
    .req1   (core1_request),
    .grant0 (core0_grant),
    .grant1 (core1_grant)
  );

  always_comb begin
    RAM_address    = '0;
    RAM_data_in    = '0;
    rw             = RW_READ;
    core0_data_out = '0;
    core1_data_out = '0;
    unique case (1'b1)
      core0_grant: begin
        RAM_address    = core0_address;
        RAM_data_in    = core0_data_in;
        rw             = core0_rw;
        core0_data_out = RAM_data_out;
      end
      core1_grant: begin
        RAM_address    = core1_address;
        RAM_data_in    = core1_data_in;
        rw             = core1_rw;
        core1_data_out = RAM_data_out;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_system_bus.sv
// Directed self-checking bench for system_bus.
// Inputs change 2ns after each rising edge; checks follow 1ns later.
module tb_system_bus;

  logic       clk;
  logic       reset;
  logic       core0_request, core1_request;
  logic       core0_grant, core1_grant;
  logic [7:0] core0_data_in, core1_data_in;
  logic [7:0] core0_data_out, core1_data_out;
  logic [8:0] core0_address, core1_address;
  logic       core0_rw, core1_rw;
  logic [8:0] RAM_address;
  logic [7:0] RAM_data_in;
  logic [7:0] RAM_data_out;
  logic       rw;

  int checks = 0;
  int errors = 0;

  system_bus #(.ADDR_W(9), .DATA_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .core0_request  (core0_request),
    .core0_grant    (core0_grant),
    .core0_data_in  (core0_data_in),
    .core0_data_out (core0_data_out),
    .core0_address  (core0_address),
    .core0_rw       (core0_rw),
    .core1_request  (core1_request),
    .core1_grant    (core1_grant),
    .core1_data_in  (core1_data_in),
    .core1_data_out (core1_data_out),
    .core1_address  (core1_address),
    .core1_rw       (core1_rw),
    .RAM_address    (RAM_address),
    .RAM_data_in    (RAM_data_in),
    .RAM_data_out   (RAM_data_out),
    .rw             (rw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic grants(input string tag,
                        input logic g0, input logic g1);
    check({tag, "_g0"}, {15'd0, core0_grant}, {15'd0, g0});
    check({tag, "_g1"}, {15'd0, core1_grant}, {15'd0, g1});
  endtask

  always @(negedge clk) begin
    checks++;
    assert (!(core0_grant && core1_grant)) else begin
      errors++;
      $error("FAIL overlap observed=11 expected=not_both");
    end
  end

  initial begin
    reset         = 1'b0;
    core0_request = 1'b1;
    core1_request = 1'b1;
    core0_data_in = 8'h11;
    core1_data_in = 8'h22;
    core0_address = 9'h1F0;
    core1_address = 9'h0AA;
    core0_rw      = 1'b1;
    core1_rw      = 1'b1;
    RAM_data_out  = 8'hFF;

    #3;
    grants("rst", 1'b0, 1'b0);
    check("rst_rw", {15'd0, rw}, 16'd0);
    check("rst_addr", {7'd0, RAM_address}, 16'd0);
    check("rst_wdata", {8'd0, RAM_data_in}, 16'd0);
    check("rst_d0", {8'd0, core0_data_out}, 16'd0);
    check("rst_d1", {8'd0, core1_data_out}, 16'd0);
    tick();
    tick();
    grants("rst_hold", 1'b0, 1'b0);

    reset = 1'b1;
    tick();
    grants("rr_first", 1'b1, 1'b0);

    core0_request = 1'b0;
    core1_request = 1'b0;
    tick();
    grants("to_idle", 1'b0, 1'b0);
    check("idle_rw", {15'd0, rw}, 16'd0);
    check("idle_addr", {7'd0, RAM_address}, 16'd0);

    core0_request = 1'b1;
    core0_address = 9'h105;
    core0_data_in = 8'hA5;
    core0_rw      = 1'b1;
    #1;
    grants("wr_pre", 1'b0, 1'b0);
    tick();
    grants("wr_grant", 1'b1, 1'b0);
    check("wr_addr", {7'd0, RAM_address}, 16'h0105);
    check("wr_data", {8'd0, RAM_data_in}, 16'h00A5);
    check("wr_rw", {15'd0, rw}, 16'd1);
    check("wr_d1", {8'd0, core1_data_out}, 16'd0);
    check("wr_d0", {8'd0, core0_data_out}, 16'h00FF);

    core0_request = 1'b0;
    core1_request = 1'b1;
    core1_rw      = 1'b0;
    RAM_data_out  = 8'h3C;
    tick();
    grants("rd_grant", 1'b0, 1'b1);
    check("rd_d1", {8'd0, core1_data_out}, 16'h003C);
    check("rd_d0", {8'd0, core0_data_out}, 16'd0);
    check("rd_addr", {7'd0, RAM_address}, 16'h00AA);
    check("rd_rw", {15'd0, rw}, 16'd0);

    core0_request = 1'b1;
    tick();
    grants("hold1", 1'b0, 1'b1);
    core1_request = 1'b0;
    tick();
    grants("ho_to0", 1'b1, 1'b0);
    core1_request = 1'b1;
    core1_address = 9'h077;
    tick();
    grants("own0_hold", 1'b1, 1'b0);
    check("own0_addr", {7'd0, RAM_address}, 16'h0105);
    core0_request = 1'b0;
    tick();
    grants("ho_to1", 1'b0, 1'b1);
    check("ho_addr", {7'd0, RAM_address}, 16'h0077);
    core0_request = 1'b1;

    for (int k = 0; k < 4; k++) begin
      if (core1_grant) core1_request = 1'b0;
      else             core0_request = 1'b0;
      tick();
      core0_request = 1'b1;
      core1_request = 1'b1;
      #1;
      grants($sformatf("fair%0d", k), (k % 2) == 0, (k % 2) == 1);
      tick();
      tick();
      grants($sformatf("fair%0d_held", k), (k % 2) == 0, (k % 2) == 1);
    end

    core1_rw = 1'b1;
    #1;
    check("mid_rw_pre", {15'd0, rw}, 16'd1);
    reset = 1'b0;
    #1;
    check("async_rw", {15'd0, rw}, 16'd0);
    grants("async", 1'b0, 1'b0);
    check("async_addr", {7'd0, RAM_address}, 16'd0);
    check("async_d1", {8'd0, core1_data_out}, 16'd0);

    tick();
    reset = 1'b1;
    tick();
    grants("post_rst", 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
